seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Time-multiplexes NUM_DIGITS hex nibbles onto one shared seven-segment bus.
- Sits directly upstream of the nibble-to-segment decoder:
  - drives its 4-bit nibble input;
  - drives the common digit-enable lines that select which digit lights.
- Provides tear-free frame updates, an anti-ghosting blank interval between digits, and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=1).
- REFRESH_DIV, 50000, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 100, cycles at the start of each slot during which no digit is enabled (0 <= BLANK_CYCLES < REFRESH_DIV).
- EN_ACTIVE_LOW, 1, 1 means an active digit drives digit_en low; 0 means it drives high.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- digits_in, input, 4*NUM_DIGITS, nibble i at bits [4i+3:4i]; digit 0 is least significant.
- dp_in, input, NUM_DIGITS, decimal-point request per digit.
- load, input, 1, single-cycle strobe that captures digits_in and dp_in.
- blank_lz, input, 1, enables leading-zero blanking.
- bin_out, output, 4, nibble for the current slot, to the decoder.
- bin_valid, output, 1, 1 means the current slot shows a digit; 0 means the slot is blanked.
- dp_out, output, 1, decimal point for the current slot.
- digit_en, output, NUM_DIGITS, one-hot digit enable with polarity per EN_ACTIVE_LOW.
- frame_tick, output, 1, one-cycle pulse at the start of each frame (slot 0).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n asynchronous assert, synchronous deassert handled externally.
  - All outputs are registered.
- Reset values:
  - Slot counter = 0, digit index = 0, FSM = BLANK.
  - pending and active registers = 0.
  - bin_out = 0, bin_valid = 0, dp_out = 0, frame_tick = 0.
  - digit_en = all inactive (all 1s if EN_ACTIVE_LOW, else all 0s).
  - Reset mid-slot forces these values immediately; scanning restarts at slot 0.
- Slot timing:
  - The cycle counter runs 0..REFRESH_DIV-1, then wraps.
  - On wrap the digit index increments modulo NUM_DIGITS.
  - The first slot (digit 0) begins on the first rising edge after rst_n release.
- FSM states:
  - BLANK: counter < BLANK_CYCLES. All digit_en inactive.
  - SHOW: BLANK_CYCLES <= counter <= REFRESH_DIV-1. digit_en[index] active if the digit is not blanked; all others inactive.
  - BLANK -> SHOW when the counter reaches BLANK_CYCLES.
  - SHOW -> BLANK on counter wrap.
  - If BLANK_CYCLES = 0, BLANK is skipped and the FSM stays in SHOW.
- Per-slot outputs:
  - bin_out, dp_out and bin_valid update on the first cycle of each slot, during BLANK.
  - They hold constant for the whole slot.
  - The decoder output is therefore settled before enable asserts.
- frame_tick:
  - Asserted for exactly the first cycle of every slot with index 0.
  - Period = NUM_DIGITS*REFRESH_DIV cycles.
- Load / tearing rule:
  - load copies digits_in and dp_in into pending.
  - pending copies to active only on the edge that starts slot 0.
  - If load coincides with that edge, digits_in and dp_in go straight to active.
  - Multiple loads within a frame: the last one wins.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i>0) is blanked when active nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked slot has bin_valid=0, bin_out=0, dp_out=0, and no digit_en asserted.
  - If a blanked digit's dp_in bit is 1, the digit is not blanked, but bin_valid=0.
  - blank_lz is sampled at each slot start.
- NUM_DIGITS=1: the index stays 0 and frame_tick pulses every REFRESH_DIV cycles.

Decomposition:
- Shared package/include seven_seg_pkg:
  - FSM state encodings (BLANK, SHOW);
  - the $clog2 width helper;
  - default NUM_DIGITS.
- One sub-module, scan_timer:
  - owns the cycle counter, digit index, FSM and frame_tick;
  - exports slot_start, show and index.
- The top level holds the pending/active registers, leading-zero logic and output registers.
- The decoder is instantiated beside this block at system level, not inside it.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, EN_ACTIVE_LOW=1):
1. Reset then free-run:
   - digit_en = 4'b1111 for cycles 0-1, then 4'b1110 for cycles 2-7.
   - Then 1111 x2 followed by 1101 x6, and so on through 1011 and 0111.
   - frame_tick at cycles 0 and 32.
2. load with digits_in=16'h1234 at cycle 5:
   - bin_out stays 0 until cycle 32.
   - Then bin_out = 4,3,2,1 on successive slots.
3. Loads 16'h00A5 at cycle 10 and 16'h0007 at cycle 20, blank_lz=1:
   - From cycle 32: slot 0 bin_out=7, bin_valid=1.
   - Slots 1-3 have bin_valid=0 and digit_en stays 4'b1111.
4. digits_in=16'h0000, dp_in=4'b0100, blank_lz=1:
   - Slot 0 shows 0.
   - Slot 2 has dp_out=1, bin_valid=0, digit_en=1011 during SHOW.
   - Slots 1 and 3 are fully blank.
5. load on the exact slot-0 start edge with 16'hBEEF: that same frame shows F,E,E,B.
6. rst_n low at cycle 13 (mid-SHOW of slot 1):
   - digit_en immediately 1111, all outputs at reset values.
   - After release, slot 0 restarts and frame_tick fires on the first edge.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner.
// Contents:
//   DEFAULT_NUM_DIGITS - default digit count
//   scan_state_e       - slot phase encoding (BLANK, SHOW)
//   width_of()         - counter width helper (never returns less than 1)
package seven_seg_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Width needed to count 0..n-1; one bit minimum so degenerate sizes still elaborate.
  function automatic int width_of(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_scan_timer.sv
// Slot timing for the seven-segment scanner.
// The cycle counter holds the slot position of the cycle that the NEXT
// rising edge begins, so every export below describes that upcoming cycle
// and the top level can register its outputs from it directly.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   slot_start  - the next edge begins a new slot (position 0)
//   show        - the next cycle is in the SHOW phase
//   index       - digit index of the slot the next cycle belongs to
//   frame_tick  - registered one-cycle pulse on the first cycle of slot 0
module scan_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 100,
  parameter int IW           = width_of(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          slot_start,
  output logic          show,
  output logic [IW-1:0] index,
  output logic          frame_tick
);

  localparam int            CW        = width_of(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic          HAS_BLANK = (BLANK_CYCLES != 0);

  logic [CW-1:0] cnt_r;
  logic [IW-1:0] idx_r;
  scan_state_e   state_r;
  scan_state_e   state_next_s;
  logic          frame_tick_r;

  assign slot_start = (cnt_r == {CW{1'b0}});
  assign index      = idx_r;
  assign show       = (state_next_s == ST_SHOW);
  assign frame_tick = frame_tick_r;

  // Slot position counter and digit index; index advances on counter wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= {CW{1'b0}};
      if (idx_r == LAST_IDX) begin
        idx_r <= {IW{1'b0}};
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Phase register: BLANK or SHOW for the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Phase transitions; with no blank interval the FSM settles in SHOW.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_END) begin
          state_next_s = ST_SHOW;
        end else begin
          state_next_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (slot_start && HAS_BLANK) begin
          state_next_s = ST_BLANK;
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      default: state_next_s = ST_BLANK;
    endcase
  end

  // Frame pulse on the first cycle of every slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= slot_start && (idx_r == {IW{1'b0}});
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared seven-segment bus.
// The nibble-to-segment decoder sits beside this block and is fed by bin_out.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   digits_in   - nibble i at [4i+3:4i], digit 0 least significant
//   dp_in       - decimal point request per digit
//   load        - strobe capturing digits_in/dp_in into the pending frame
//   blank_lz    - enable leading-zero blanking (sampled at slot start)
//   bin_out     - nibble for the current slot
//   bin_valid   - 1 when the current slot shows a digit
//   dp_out      - decimal point for the current slot
//   digit_en    - one-hot digit enable, polarity set by EN_ACTIVE_LOW
//   frame_tick  - one-cycle pulse at the start of each frame
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 100,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              bin_out,
  output logic                    bin_valid,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int            N      = NUM_DIGITS;
  localparam int            IW     = width_of(N);
  localparam int            DW     = 4 * N;
  localparam logic          ACT_LO = (EN_ACTIVE_LOW != 0);
  localparam logic [N-1:0]  EN_OFF = ACT_LO ? {N{1'b1}} : {N{1'b0}};

  logic          slot_start_s;
  logic          show_s;
  logic [IW-1:0] index_s;
  logic          frame_start_s;

  logic [DW-1:0] pend_dig_r;
  logic [N-1:0]  pend_dp_r;
  logic [DW-1:0] act_dig_r;
  logic [N-1:0]  act_dp_r;
  logic [DW-1:0] act_dig_next_s;
  logic [N-1:0]  act_dp_next_s;

  logic [N-1:0]  lz_zero_s;
  logic          zero_run_s;
  logic [N-1:0]  onehot_s;
  logic [3:0]    nib_sel_s;
  logic          dp_sel_s;
  logic          lz_sel_s;

  logic          slot_lit_s;
  logic          slot_valid_s;
  logic          slot_dp_s;
  logic [3:0]    slot_bin_s;
  logic          lit_now_s;
  logic [N-1:0]  en_next_s;

  logic          slot_lit_r;
  logic [3:0]    bin_r;
  logic          bin_valid_r;
  logic          dp_r;
  logic [N-1:0]  digit_en_r;

  scan_timer #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IW          (IW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_start(slot_start_s),
    .show      (show_s),
    .index     (index_s),
    .frame_tick(frame_tick)
  );

  assign frame_start_s = slot_start_s && (index_s == {IW{1'b0}});

  // Frame contents for the next cycle: pending is adopted only at frame start,
  // and a load on that very edge bypasses pending so it is not a frame late.
  always_comb begin
    act_dig_next_s = act_dig_r;
    act_dp_next_s  = act_dp_r;
    if (frame_start_s) begin
      if (load) begin
        act_dig_next_s = digits_in;
        act_dp_next_s  = dp_in;
      end else begin
        act_dig_next_s = pend_dig_r;
        act_dp_next_s  = pend_dp_r;
      end
    end else begin
      act_dig_next_s = act_dig_r;
      act_dp_next_s  = act_dp_r;
    end
  end

  // Leading-zero map: scan from the top digit down while nibbles stay zero.
  always_comb begin
    lz_zero_s  = {N{1'b0}};
    zero_run_s = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      zero_run_s   = zero_run_s & (act_dig_next_s[4*i +: 4] == 4'h0);
      lz_zero_s[i] = zero_run_s & blank_lz & (i != 0);
    end
  end

  // Current-digit select as an AND-OR mux, plus its one-hot position.
  always_comb begin
    nib_sel_s = 4'h0;
    dp_sel_s  = 1'b0;
    lz_sel_s  = 1'b0;
    onehot_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot_s[i] = (index_s == IW'(i));
      nib_sel_s   = nib_sel_s | (act_dig_next_s[4*i +: 4] & {4{onehot_s[i]}});
      dp_sel_s    = dp_sel_s | (act_dp_next_s[i] & onehot_s[i]);
      lz_sel_s    = lz_sel_s | (lz_zero_s[i] & onehot_s[i]);
    end
  end

  // Slot content: a leading zero with a decimal point still lights for the dot.
  always_comb begin
    slot_lit_s   = 1'b1;
    slot_valid_s = 1'b1;
    slot_dp_s    = dp_sel_s;
    slot_bin_s   = nib_sel_s;
    if (lz_sel_s && !dp_sel_s) begin
      slot_lit_s   = 1'b0;
      slot_valid_s = 1'b0;
      slot_dp_s    = 1'b0;
      slot_bin_s   = 4'h0;
    end else if (lz_sel_s) begin
      slot_lit_s   = 1'b1;
      slot_valid_s = 1'b0;
      slot_dp_s    = 1'b1;
      slot_bin_s   = nib_sel_s;
    end else begin
      slot_lit_s   = 1'b1;
      slot_valid_s = 1'b1;
      slot_dp_s    = dp_sel_s;
      slot_bin_s   = nib_sel_s;
    end
  end

  // Enable for the next cycle; the fresh slot decision is needed when SHOW
  // starts on the slot edge itself (no blank interval).
  always_comb begin
    lit_now_s = slot_lit_r;
    en_next_s = EN_OFF;
    if (slot_start_s) begin
      lit_now_s = slot_lit_s;
    end else begin
      lit_now_s = slot_lit_r;
    end
    if (show_s && lit_now_s) begin
      en_next_s = ACT_LO ? ~onehot_s : onehot_s;
    end else begin
      en_next_s = EN_OFF;
    end
  end

  // Pending frame: the last load before frame start wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig_r <= {DW{1'b0}};
      pend_dp_r  <= {N{1'b0}};
    end else if (load) begin
      pend_dig_r <= digits_in;
      pend_dp_r  <= dp_in;
    end else begin
      pend_dig_r <= pend_dig_r;
      pend_dp_r  <= pend_dp_r;
    end
  end

  // Active frame register, changes only at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dig_r <= {DW{1'b0}};
      act_dp_r  <= {N{1'b0}};
    end else begin
      act_dig_r <= act_dig_next_s;
      act_dp_r  <= act_dp_next_s;
    end
  end

  // Per-slot outputs, captured on the slot edge and held for the whole slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_lit_r  <= 1'b0;
      bin_r       <= 4'h0;
      bin_valid_r <= 1'b0;
      dp_r        <= 1'b0;
    end else if (slot_start_s) begin
      slot_lit_r  <= slot_lit_s;
      bin_r       <= slot_bin_s;
      bin_valid_r <= slot_valid_s;
      dp_r        <= slot_dp_s;
    end else begin
      slot_lit_r  <= slot_lit_r;
      bin_r       <= bin_r;
      bin_valid_r <= bin_valid_r;
      dp_r        <= dp_r;
    end
  end

  // Digit enable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en_r <= EN_OFF;
    end else begin
      digit_en_r <= en_next_s;
    end
  end

  assign bin_out   = bin_r;
  assign bin_valid = bin_valid_r;
  assign dp_out    = dp_r;
  assign digit_en  = digit_en_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8 cycles/slot, 2 blank).
// Cycle k is the clock period following the k-th rising edge after reset
// release (k = 0 first). Stimulus pushes hand-computed expectations tagged
// with a cycle number; the monitor pops and compares them on falling edges.
// Cycle tag -1 means "while reset is asserted".
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bin_out;
  logic        bin_valid;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_tick;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .EN_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dp_out    (dp_out),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [3:0] bin;
    logic       vld;
    logic       dp;
    logic       ft;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;
  int   edge_cnt;

  logic [3:0] en_tab [4];
  logic [15:0] val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Monitor: compare every expectation due at this cycle; report skipped ones.
  always @(negedge clk) begin : monitor
    int   cur;
    exp_t e;
    cur = rst_n ? (edge_cnt - 1) : -1;
    while (sb_q.size() > 0 &&
           (sb_q[0].cyc == cur || (rst_n && sb_q[0].cyc >= 0 && sb_q[0].cyc < cur))) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc != cur) begin
        n_fail++;
        $display("FAIL %s cyc %0d: sample point passed without compare (now %0d)", e.tag, e.cyc, cur);
      end else if ({digit_en, bin_out, bin_valid, dp_out, frame_tick} !==
                   {e.en, e.bin, e.vld, e.dp, e.ft}) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got en=%b bin=%h vld=%b dp=%b ft=%b, want en=%b bin=%h vld=%b dp=%b ft=%b",
                 e.tag, cur, digit_en, bin_out, bin_valid, dp_out, frame_tick,
                 e.en, e.bin, e.vld, e.dp, e.ft);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] en, input logic [3:0] bin,
                      input logic v, input logic dp, input logic ft, input string tag);
    exp_t e;
    e.cyc = c; e.en = en; e.bin = bin; e.vld = v; e.dp = dp; e.ft = ft; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_reset(input string tag);
    push(-1, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Assert reset (checked while low), then release just after a falling edge.
  task automatic start_reset(input string tag);
    push_reset(tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Return at the falling edge just before rising edge number e.
  task automatic wait_edge(input int e);
    int k;
    k = 0;
    @(negedge clk);
    while (edge_cnt != e && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (edge_cnt != e) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_edge: got edge %0d, wanted edge %0d", edge_cnt, e);
    end
  endtask

  // Present load so that rising edge e samples it.
  task automatic load_at(input int e, input logic [15:0] d, input logic [3:0] p);
    wait_edge(e);
    #1;
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s drain: got %0d expectations still queued, want 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1; load = 1'b0; digits_in = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
    en_tab[0] = 4'b1110; en_tab[1] = 4'b1101; en_tab[2] = 4'b1011; en_tab[3] = 4'b0111;

    // 1: free run after reset, all digits 0, no blanking.
    start_reset("t1_reset");
    for (int c = 0; c < 40; c++) begin
      push(c, ((c % 8) < 2) ? 4'b1111 : en_tab[(c / 8) % 4], 4'h0, 1'b1, 1'b0,
           ((c % 32) == 0) ? 1'b1 : 1'b0, "t1_scan");
    end
    drain("t1");

    // 2: load 1234 mid-frame; shows only from the next frame, digit 0 first.
    start_reset("t2_reset");
    val = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) push(32, 4'b1111, 4'h4, 1'b1, 1'b0, 1'b1, "t2_frame");
      push(3 + 8 * k, en_tab[k % 4], (k < 4) ? 4'h0 : val[4 * (k - 4) +: 4],
           1'b1, 1'b0, 1'b0, "t2_slot");
    end
    load_at(5, 16'h1234, 4'b0000);
    drain("t2");

    // 3: two loads, last wins; leading zeros blanked.
    blank_lz = 1'b1;
    start_reset("t3_reset");
    push(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, "t3_f0_d0");
    push(12, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t3_f0_d1");
    push(32, 4'b1111, 4'h7, 1'b1, 1'b0, 1'b1, "t3_d0_start");
    push(34, 4'b1110, 4'h7, 1'b1, 1'b0, 1'b0, "t3_d0_show");
    push(39, 4'b1110, 4'h7, 1'b1, 1'b0, 1'b0, "t3_d0_end");
    push(42, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t3_d1");
    push(50, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t3_d2");
    push(58, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t3_d3");
    load_at(10, 16'h00A5, 4'b0000);
    load_at(20, 16'h0007, 4'b0000);
    drain("t3");

    // 4: all zeros with a decimal point on digit 2.
    start_reset("t4_reset");
    push(36, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, "t4_d0");
    push(44, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t4_d1");
    push(48, 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, "t4_d2_blank");
    push(52, 4'b1011, 4'h0, 1'b0, 1'b1, 1'b0, "t4_d2_show");
    push(60, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0, "t4_d3");
    load_at(3, 16'h0000, 4'b0100);
    drain("t4");

    // 5: load on the frame-start edge is shown in that same frame.
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    start_reset("t5_reset");
    push(31, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0, "t5_old");
    push(32, 4'b1111, 4'hF, 1'b1, 1'b0, 1'b1, "t5_start");
    push(35, 4'b1110, 4'hF, 1'b1, 1'b0, 1'b0, "t5_d0");
    push(43, 4'b1101, 4'hE, 1'b1, 1'b0, 1'b0, "t5_d1");
    push(51, 4'b1011, 4'hE, 1'b1, 1'b0, 1'b0, "t5_d2");
    push(59, 4'b0111, 4'hB, 1'b1, 1'b0, 1'b0, "t5_d3");
    load_at(10, 16'h1111, 4'b0000);
    load_at(32, 16'hBEEF, 4'b0000);
    drain("t5");

    // 6: reset in mid-SHOW of slot 1 clears outputs and the pending frame.
    start_reset("t6_reset");
    push(12, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0, "t6_pre");
    load_at(3, 16'h1234, 4'b0000);
    wait_edge(14);
    push_reset("t6_midslot");
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    push(0,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b1, "t6_restart");
    push(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, "t6_show");
    push(32, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1, "t6_pend_clr");
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
